div_sequencer: RTL and testbench

- Multicycle signed 32-bit divide controller for the processor's multdiv unit.
- Owns no arithmetic of its own. It time-shares one external 32-bit subtractor (S = A - B, two's complement) for three jobs: operand magnitude conversion, restoring-division iterations, and result sign correction.
- Exposes the ctrl_DIV / data_resultRDY / data_exception handshake used by the pipeline stall logic.

---
 rtl/div_sequencer.sv | 161 ++++++++++++++++
 tb/tb_div_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Multicycle signed divide controller: restoring division on magnitudes, driving one
// shared external subtractor for operand negation, iteration and result sign fix-up.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] sub_A,
    output logic [WIDTH-1:0] sub_B,
    input  logic [WIDTH-1:0] sub_S,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        NEG_A,
        NEG_B,
        ITER,
        NEG_Q,
        NEG_R,
        DONE
    } state_t;

    state_t state, state_next;

    // q_reg starts as |dividend| and shifts out dividend bits as quotient bits shift in.
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CNT_W-1:0] count;
    logic             sign_q;
    logic             sign_r;
    logic             dz;

    logic [WIDTH-1:0] r_shift;
    logic             carry;
    logic             borrow;
    logic             accept;

    // A set top bit of R means the shifted partial remainder already exceeds any divisor.
    always_comb begin
        r_shift = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
        carry   = r_reg[WIDTH-1];
        borrow  = (r_shift[WIDTH-1] ^ d_reg[WIDTH-1]) ? d_reg[WIDTH-1] : sub_S[WIDTH-1];
        accept  = carry | ~borrow;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default before the case, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        sub_A      = '0;
        sub_B      = '0;
        case (state)
            IDLE:  if (ctrl_DIV) state_next = NEG_A;
            NEG_A: begin
                sub_B      = q_reg;
                state_next = NEG_B;
            end
            NEG_B: begin
                sub_B      = d_reg;
                state_next = ITER;
            end
            ITER: begin
                sub_A = r_shift;
                sub_B = d_reg;
                if (count == LAST_ITER) state_next = NEG_Q;
            end
            NEG_Q: begin
                sub_B      = q_reg;
                state_next = NEG_R;
            end
            NEG_R: begin
                sub_B      = r_reg;
                state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy           = (state != IDLE);
    assign data_resultRDY = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_reg          <= '0;
            r_reg          <= '0;
            d_reg          <= '0;
            count          <= '0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            dz             <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_DIV) begin
                        q_reg  <= data_operandA;
                        d_reg  <= data_operandB;
                        sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        sign_r <= data_operandA[WIDTH-1];
                        dz     <= (data_operandB == '0);
                    end
                end
                NEG_A: begin
                    if (q_reg[WIDTH-1]) q_reg <= sub_S;
                end
                NEG_B: begin
                    if (d_reg[WIDTH-1]) d_reg <= sub_S;
                    r_reg <= '0;
                    count <= '0;
                end
                ITER: begin
                    if (accept) begin
                        r_reg <= sub_S;
                        q_reg <= {q_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        r_reg <= r_shift;
                        q_reg <= {q_reg[WIDTH-2:0], 1'b0};
                    end
                    count <= count + CNT_W'(1);
                end
                NEG_Q: begin
                    if (sign_q) q_reg <= sub_S;
                end
                NEG_R: begin
                    // Outputs load here so they are already valid during the DONE pulse.
                    if (sign_r) r_reg <= sub_S;
                    data_result    <= dz ? '0 : q_reg;
                    data_remainder <= dz ? '0 : (sign_r ? sub_S : r_reg);
                    data_exception <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer; models the shared subtractor and
// checks results, latency, busy width, ignored starts and asynchronous reset.
module tb_div_sequencer;

    logic        clock;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] sub_A;
    logic [31:0] sub_B;
    logic [31:0] sub_S;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

    div_sequencer #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .sub_A          (sub_A),
        .sub_B          (sub_B),
        .sub_S          (sub_S),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    assign sub_S = sub_A - sub_B;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Starts a divide on the next falling edge; the following rising edge is edge 0.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input logic exp_ex, input string tag);
        int lat;
        int busy_cycles;
        lat         = 0;
        busy_cycles = 0;
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        if (busy) busy_cycles++;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clock);
            #1;
            if (busy) busy_cycles++;
            if (data_resultRDY) begin
                lat = e;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'd36);
        check({tag, " quotient"}, data_result, exp_q);
        check({tag, " remainder"}, data_remainder, exp_r);
        check({tag, " exception"}, {31'd0, data_exception}, {31'd0, exp_ex});
        check({tag, " busy_cycles"}, 32'(busy_cycles), 32'd37);
        @(posedge clock);
        #1;
        check({tag, " rdy_one_cycle"}, {31'd0, data_resultRDY}, 32'd0);
        check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
        check({tag, " quotient_held"}, data_result, exp_q);
    endtask

    initial begin
        logic saw_rdy;
        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #2;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset result", data_result, 32'd0);
        check("reset remainder", data_remainder, 32'd0);
        check("reset sub_A", sub_A, 32'd0);
        check("reset sub_B", sub_B, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        do_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "100/7");
        do_div(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, "-100/7");
        do_div(32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, "100/-7");
        do_div(32'h7FFF_FFFF, 32'h4000_0001, 32'd1, 32'h3FFF_FFFE, 1'b0, "max/big");
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, "min/-1");
        do_div(32'd7, 32'd0, 32'd0, 32'd0, 1'b1, "7/0");

        // Start pulses during ITER, NEG_R and DONE must all be ignored.
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd1000;
        data_operandB = 32'd10;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd50;
        data_operandB = 32'd5;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        repeat (30) @(posedge clock);
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd77;
        data_operandB = 32'd3;
        @(posedge clock);
        #1;
        check("ignore rdy_at_36", {31'd0, data_resultRDY}, 32'd1);
        check("ignore quotient", data_result, 32'd100);
        check("ignore remainder", data_remainder, 32'd0);
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        check("ignore done_pulse_busy", {31'd0, busy}, 32'd0);
        check("ignore quotient_held", data_result, 32'd100);
        do_div(32'd80, 32'd7, 32'd11, 32'd3, 1'b0, "80/7 after idle");

        // Asynchronous reset between edges, ten cycles into an operation.
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd1000;
        data_operandB = 32'd10;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        repeat (10) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset rdy", {31'd0, data_resultRDY}, 32'd0);
        check("midreset result", data_result, 32'd0);
        check("midreset remainder", data_remainder, 32'd0);
        check("midreset exception", {31'd0, data_exception}, 32'd0);
        check("midreset sub_A", sub_A, 32'd0);
        check("midreset sub_B", sub_B, 32'd0);
        @(negedge clock);
        reset   = 1'b0;
        saw_rdy = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (data_resultRDY || busy) saw_rdy = 1'b1;
        end
        check("midreset no_rdy", {31'd0, saw_rdy}, 32'd0);
        do_div(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, "9/3 after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
